ram_boot_loader: RTL and testbench
==================================

Name: ram_boot_loader

Overview:
- Sits between cpu0 and the ram macro, upstream of ram.
- After reset it holds cpu0 in reset and fills ram from an external byte stream, assembling big-endian 32-bit words.
- Once the image is loaded it releases cpu0 and becomes a transparent pass-through of cpu0's mar/mdr/m_rw/m_en onto the ram port.

Parameters:
- AW, 10, ram word-address width (ram depth = 2**AW words).
- MAX_WORDS, 1024, maximum image length in words; must be ≤ 2**AW.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_data  in  8  image byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  qualifies the final byte of the image; sampled only on handshake.
- in_ready  out  1  loader accepts a byte; handshake = in_valid & in_ready.
- cpu_mar  in  32  cpu0 byte address.
- cpu_mdr  in  32  cpu0 write data.
- cpu_m_rw  in  1  cpu0 direction, 1 = read, 0 = write.
- cpu_m_en  in  1  cpu0 memory enable.
- ram_addr  out  AW  ram word address.
- ram_data  out  32  ram write data.
- ram_wren  out  1  ram write enable.
- cpu_reset  out  1  active-high reset to cpu0; held 1 until load completes.
- done  out  1  image loaded, pass-through active.
- err  out  1  image overflowed MAX_WORDS; sticky until rst.
- word_cnt  out  AW+1  number of words written to ram.

Behaviour:
- Reset (rst=0 at edge):
  - state=LOAD, byte_idx=0, word_cnt=0, shift register=0.
  - ram_wren=0, ram_addr=0, ram_data=0.
  - cpu_reset=1, done=0, err=0, in_ready=0 during reset; in_ready=1 from the first cycle after rst=1.
  - Reset asserted mid-load discards the partial word and restarts at address 0.
- States:
  - LOAD: accept bytes.
  - WRITE: issue a one-cycle ram write.
  - RUN: pass-through.
- LOAD:
  - in_ready=1.
  - On handshake, the byte goes into lane byte_idx: idx 0 → bits [31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0]; then byte_idx++.
  - Go to WRITE when the byte at idx 3 is accepted, or when in_last=1 on any accepted byte. On in_last, unfilled lanes are zero-padded.
- WRITE (exactly one cycle):
  - Registered outputs ram_wren=1, ram_addr=word_cnt[AW-1:0], ram_data=assembled word.
  - in_ready=0.
  - Next edge: word_cnt++, byte_idx=0, shift register cleared.
  - Next state is RUN if the word was tagged last or word_cnt+1 == MAX_WORDS; otherwise LOAD.
  - Write latency: ram_wren is high in the cycle immediately after the handshake that completes the word.
- Overflow:
  - If the word just written makes word_cnt == MAX_WORDS and that word was not last, set err=1 and go to RUN.
  - in_ready stays 0 from then on; the remaining stream is never accepted.
- RUN:
  - done=1, cpu_reset=0 (both registered, asserted on the first RUN cycle), in_ready=0.
  - Combinational pass-through: ram_addr = cpu_mar[AW+1:2], ram_data = cpu_mdr, ram_wren = cpu_m_en & ~cpu_m_rw.
  - cpu_mar[1:0] and the upper bits are ignored (no aliasing check).
- Other rules:
  - in_valid with in_ready=0: byte not consumed, no state change; source must hold data.
  - in_last on an empty stream (no bytes) is impossible; loading zero words is not supported. Leaving the stream idle keeps the loader in LOAD indefinitely with cpu_reset=1.
  - The cpu bus inputs are ignored in LOAD/WRITE; ram_wren is driven only by the loader there.
  - word_cnt saturates at MAX_WORDS.
  - The only exit from RUN is rst=0.

Test Plan:
- Stream 8 bytes 12 34 56 78 9A BC DE F0, in_last on F0 → ram_wren pulses at addr 0 with 0x12345678, then at addr 1 with 0x9ABCDEF0. done=1, cpu_reset=0 the cycle after the 2nd write; word_cnt=2, err=0.
- Stream 5 bytes 01 02 03 04 AA, in_last on AA → writes addr 0 = 0x01020304 and addr 1 = 0xAA000000 (zero pad); word_cnt=2.
- MAX_WORDS=4, stream 20 bytes with no in_last → 4 writes at addr 0..3; err=1, done=1, in_ready=0; bytes 17–20 never accepted.
- Random in_valid gaps (~50% duty) on the 8-byte image → identical ram contents and write order; no byte lost or duplicated.
- After done: cpu_mar=0x0000000C, cpu_mdr=0xCAFEBABE, cpu_m_en=1, cpu_m_rw=0 → same cycle ram_addr=3, ram_data=0xCAFEBABE, ram_wren=1. With cpu_m_rw=1 → ram_wren=0.
- rst=0 for one cycle after 6 bytes of a 12-byte image, then restream the full image → loading restarts at addr 0; cpu_reset=1 throughout; final word_cnt=3.

Source files
------------

// File: rtl/ram_boot_loader_if.sv
// Byte-stream, cpu0 memory bus and ram port bundled for the boot loader.
// The loader connects through slave and the stream/cpu/ram environment through master.
interface ram_boot_loader_if #(
    parameter int AW = 10
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [31:0]   cpu_mar;
    logic [31:0]   cpu_mdr;
    logic          cpu_m_rw;
    logic          cpu_m_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic          ram_wren;

    modport slave (
        input  in_data, in_valid, in_last, cpu_mar, cpu_mdr, cpu_m_rw, cpu_m_en,
        output in_ready, ram_addr, ram_data, ram_wren
    );

    modport master (
        output in_data, in_valid, in_last, cpu_mar, cpu_mdr, cpu_m_rw, cpu_m_en,
        input  in_ready, ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/ram_boot_loader.sv
// Boot loader: holds cpu0 in reset while packing a byte stream into big-endian
// ram words, then hands the ram port to cpu0 as a transparent pass-through.
module ram_boot_loader #(
    parameter int AW        = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    ram_boot_loader_if.slave  bus,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [AW:0]       word_cnt
);
    typedef enum logic [1:0] {LOAD = 2'd0, WRITE = 2'd1, RUN = 2'd2} state_t;

    localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_WORDS);

    state_t      state, state_nx;
    logic [1:0]  byte_idx;
    logic [31:0] shreg;
    logic [31:0] merged;
    logic        last_q;
    logic        load_rdy;
    logic        hs;
    logic [AW:0] cnt_inc;
    logic        at_max;
    logic        unused_mar;

    // in_ready is gated by rst so it reads 0 for the whole reset interval.
    assign load_rdy     = rst & (state == LOAD);
    assign hs           = bus.in_valid & load_rdy;
    assign bus.in_ready = load_rdy;
    assign cnt_inc      = word_cnt + 1'b1;
    assign at_max       = (cnt_inc == MAX_CNT);
    assign unused_mar   = ^{bus.cpu_mar[31:AW+2], bus.cpu_mar[1:0]};

    // Lane for idx n starts at bit 8*(3-n), i.e. {~n, 3'b000} for a 2-bit idx.
    always_comb begin
        merged = shreg;
        merged[{~byte_idx, 3'b000} +: 8] = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= LOAD;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.ram_addr = '0;
        bus.ram_data = '0;
        bus.ram_wren = 1'b0;
        case (state)
            LOAD: begin
                if (hs && (byte_idx == 2'd3 || bus.in_last)) state_nx = WRITE;
            end
            WRITE: begin
                bus.ram_wren = 1'b1;
                bus.ram_addr = word_cnt[AW-1:0];
                bus.ram_data = shreg;
                state_nx     = (last_q || at_max) ? RUN : LOAD;
            end
            RUN: begin
                bus.ram_addr = bus.cpu_mar[AW+1:2];
                bus.ram_data = bus.cpu_mdr;
                bus.ram_wren = bus.cpu_m_en & ~bus.cpu_m_rw;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_idx  <= 2'd0;
            shreg     <= '0;
            last_q    <= 1'b0;
            word_cnt  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (hs) begin
                        shreg    <= merged;
                        byte_idx <= byte_idx + 2'd1;
                        last_q   <= bus.in_last;
                    end
                end
                WRITE: begin
                    if (word_cnt != MAX_CNT) word_cnt <= cnt_inc;
                    byte_idx <= 2'd0;
                    shreg    <= '0;
                    // Filling the last slot without an in_last tag means the image overflowed.
                    if (last_q || at_max) begin
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                        err       <= at_max & ~last_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_boot_loader.sv
// Self-checking bench for ram_boot_loader: random byte streams compared with a
// word-level image model, plus pass-through and reset scenarios.
module tb_ram_boot_loader;
    localparam int AW   = 5;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_reset;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;

    always #5 clk = ~clk;

    ram_boot_loader_if #(.AW(AW)) bus ();

    ram_boot_loader #(.AW(AW), .MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err),
        .word_cnt  (word_cnt)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          last_wr_cyc   = 0;
    int          done_cyc      = 0;
    bit          done_seen     = 0;
    int          bad_cpu_reset = 0;

    // Ram-port monitor: records every loader write, cpu_reset while loading, first done.
    initial forever begin
        @(negedge clk);
        #2;
        cyc++;
        if (rst && !done && bus.ram_wren === 1'b1) begin
            wr_addr_q.push_back(int'(bus.ram_addr));
            wr_data_q.push_back(bus.ram_data);
            last_wr_cyc = cyc;
        end
        if (rst && !done && cpu_reset !== 1'b1) bad_cpu_reset++;
        if (rst && done === 1'b1 && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.cpu_m_en = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        done_seen     = 0;
        bad_cpu_reset = 0;
    endtask

    task automatic drive_stream(input logic [7:0] b[$], input bit with_last,
                                input int gap_pct, output int accepted);
        accepted = 0;
        for (int i = 0; i < b.size(); i++) begin
            bit got = 0;
            if ($urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                repeat ($urandom_range(2, 1)) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            bus.in_last  = with_last && (i == b.size() - 1);
            for (int t = 0; t < 8 && !got; t++) begin
                #1;
                got = (bus.in_ready === 1'b1);
                @(negedge clk);
            end
            if (got) begin
                accepted++;
                if (bus.in_last || (accepted % 4 == 0)) begin
                    #1;
                    checks++;
                    if (bus.ram_wren !== 1'b1) begin
                        failures++;
                        $display("FAIL wr_latency byte=%0d ram_wren=%b want=1", accepted, bus.ram_wren);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        bus.cpu_mar  = 32'h0000_000C;
        bus.cpu_mdr  = 32'hCAFE_BABE;
        bus.cpu_m_rw = 1'b0;
        bus.cpu_m_en = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.in_ready, cpu_reset, done, err} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_ctl ready/cpu_reset/done/err=%b want=0100",
                     {bus.in_ready, cpu_reset, done, err});
        end
        checks++;
        if (word_cnt !== '0 || bus.ram_wren !== 1'b0 || bus.ram_addr !== '0 || bus.ram_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_ram cnt=%0d wren=%b addr=%0d data=%h want 0/0/0/0",
                     word_cnt, bus.ram_wren, bus.ram_addr, bus.ram_data);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b ram_wren=%b want 1/0", bus.in_ready, bus.ram_wren);
        end
        bus.cpu_m_en = 1'b0;
    endtask

    task automatic test_image(input string name, input logic [7:0] b[$], input bit with_last,
                              input int gap_pct, input int rst_cycles);
        logic [31:0] exp_w[$];
        logic [31:0] w;
        int n = b.size();
        int nw, acc, exp_acc, got_n;
        bit exp_err;
        nw = with_last ? (n + 3) / 4 : n / 4;
        for (int k = 0; k < nw && k < MAXW; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++)
                if (4 * k + j < n) w = w | (32'(b[4 * k + j]) << (24 - 8 * j));
            exp_w.push_back(w);
        end
        exp_err = with_last ? (nw > MAXW) : (nw >= MAXW);
        exp_acc = (n < 4 * MAXW) ? n : 4 * MAXW;

        do_reset(rst_cycles);
        drive_stream(b, with_last, gap_pct, acc);
        for (int t = 0; t < 20 && done !== 1'b1; t++) @(negedge clk);
        #3;

        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL %s.done done=%b cpu_reset=%b want 1/0", name, done, cpu_reset);
        end
        checks++;
        if (acc != exp_acc) begin
            failures++;
            $display("FAIL %s.accepted got=%0d want=%0d", name, acc, exp_acc);
        end
        got_n = wr_addr_q.size();
        checks++;
        if (got_n != exp_w.size()) begin
            failures++;
            $display("FAIL %s.nwrites got=%0d want=%0d", name, got_n, exp_w.size());
        end
        for (int k = 0; k < got_n && k < exp_w.size(); k++) begin
            checks++;
            if (wr_addr_q[k] != k || wr_data_q[k] !== exp_w[k]) begin
                failures++;
                $display("FAIL %s.write%0d addr=%0d data=%h want addr=%0d data=%h",
                         name, k, wr_addr_q[k], wr_data_q[k], k, exp_w[k]);
            end
        end
        checks++;
        if (word_cnt !== (AW+1)'(exp_w.size()) || err !== exp_err) begin
            failures++;
            $display("FAIL %s.status word_cnt=%0d err=%b want %0d/%b",
                     name, word_cnt, err, exp_w.size(), exp_err);
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bad_cpu_reset != 0) begin
            failures++;
            $display("FAIL %s.run in_ready=%b bad_cpu_reset=%0d want 0/0", name, bus.in_ready, bad_cpu_reset);
        end
        checks++;
        if (!done_seen || done_cyc != last_wr_cyc + 1) begin
            failures++;
            $display("FAIL %s.done_timing done_cyc=%0d want=%0d", name, done_cyc, last_wr_cyc + 1);
        end
    endtask

    task automatic test_passthrough();
        logic [AW-1:0] exp_a;
        @(negedge clk);
        bus.cpu_mar  = 32'h0000_000C;
        bus.cpu_mdr  = 32'hCAFE_BABE;
        bus.cpu_m_en = 1'b1;
        bus.cpu_m_rw = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.ram_addr !== 5'd3 || bus.ram_data !== 32'hCAFE_BABE || bus.ram_wren !== 1'b1) begin
            failures++;
            $display("FAIL pass_write addr=%0d data=%h wren=%b want 3/cafebabe/1",
                     bus.ram_addr, bus.ram_data, bus.ram_wren);
        end
        bus.cpu_m_rw = 1'b1;
        #1;
        checks++;
        if (bus.ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL pass_read wren=%b want=0", bus.ram_wren);
        end
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            bus.cpu_mar  = $urandom;
            bus.cpu_mdr  = $urandom;
            bus.cpu_m_en = 1'($urandom_range(1));
            bus.cpu_m_rw = 1'($urandom_range(1));
            exp_a = AW'(bus.cpu_mar >> 2);
            #1;
            checks++;
            if (bus.ram_addr !== exp_a || bus.ram_data !== bus.cpu_mdr ||
                bus.ram_wren !== (bus.cpu_m_en & ~bus.cpu_m_rw) || done !== 1'b1 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL pass_rand%0d addr=%0d data=%h wren=%b done=%b want addr=%0d data=%h wren=%b done=1",
                         r, bus.ram_addr, bus.ram_data, bus.ram_wren, done,
                         exp_a, bus.cpu_mdr, bus.cpu_m_en & ~bus.cpu_m_rw);
            end
        end
        bus.cpu_m_en = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] img[$];
        int acc;
        for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
        do_reset(2);
        drive_stream(img[0:5], 1'b0, 0, acc);
        #1;
        checks++;
        if (acc != 6 || word_cnt !== 6'd1 || cpu_reset !== 1'b1 || done !== 1'b0 || bad_cpu_reset != 0) begin
            failures++;
            $display("FAIL midrst.partial acc=%0d cnt=%0d cpu_reset=%b done=%b want 6/1/1/0",
                     acc, word_cnt, cpu_reset, done);
        end
        test_image("midrst", img, 1'b1, 0, 1);
    endtask

    task automatic test_random();
        logic [7:0] img[$];
        int n;
        for (int r = 0; r < 6; r++) begin
            img.delete();
            n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            test_image($sformatf("rand%0d", r), img, 1'b1, $urandom_range(60), 2);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst = 1'b0;

        test_reset();
        q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        test_image("basic", q, 1'b1, 0, 2);
        test_passthrough();
        for (int r = 0; r < 3; r++) test_image("gaps", q, 1'b1, 50, 2);
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
        test_image("pad5", q, 1'b1, 0, 2);
        q.delete();
        for (int i = 1; i <= 20; i++) q.push_back(8'(i));
        test_image("overflow", q, 1'b0, 0, 2);
        test_image("exact_max", q[0:15], 1'b1, 0, 2);
        test_reset_mid_load();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
